// File: rtl/vx_stream_lru_arbiter.sv
// N-to-1 valid/ready stream arbiter with least-recently-granted fairness.
// Define VX_STREAM_ARB_OUTBUF_EN to insert a 2-entry output skid buffer (latency 1, no ready_out->ready_in path).
module vx_stream_lru_arbiter #(
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned DATAW      = 32,
    parameter int unsigned SELW       = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_INPUTS-1:0]       valid_in,
    input  logic [NUM_INPUTS*DATAW-1:0] data_in,
    output logic [NUM_INPUTS-1:0]       ready_in,
    output logic                        valid_out,
    output logic [DATAW-1:0]            data_out,
    output logic [SELW-1:0]             sel_out,
    input  logic                        ready_out
);

    // Flat position of pair (i,j), i<j, in the upper-triangular priority vector.
    function automatic int unsigned pair_idx(input int unsigned i, input int unsigned j);
        return i * NUM_INPUTS - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

    logic                  arb_valid;
    logic [DATAW-1:0]      arb_data;
    logic [SELW-1:0]       arb_sel;
    logic [NUM_INPUTS-1:0] arb_grant;
    logic                  arb_ready;
    logic                  arb_fire;

    assign ready_in = reset ? '0 : (arb_grant & {NUM_INPUTS{arb_ready}});
    assign arb_fire = arb_valid && arb_ready && !reset;

    if (NUM_INPUTS == 1) begin : g_single
        assign arb_valid = valid_in[0];
        assign arb_data  = data_in[DATAW-1:0];
        assign arb_sel   = '0;
        assign arb_grant = '1;
    end else begin : g_multi
        localparam int unsigned NPAIRS = NUM_INPUTS * (NUM_INPUTS - 1) / 2;

        logic [NPAIRS-1:0]                prio_q;
        logic [NPAIRS-1:0]                prio_d;
        logic [NUM_INPUTS*NUM_INPUTS-1:0] beats;
        logic [NUM_INPUTS-1:0]            win;

        // beats[i*N+j]: input i outranks input j; a winner outranks every other requester.
        for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_row
            for (genvar j = 0; j < NUM_INPUTS; j++) begin : g_col
                if (i < j) begin : g_upper
                    localparam int unsigned P = pair_idx(i, j);
                    assign beats[i*NUM_INPUTS+j] = !prio_q[P];
                    assign prio_d[P] = !arb_fire     ? prio_q[P] :
                                       arb_grant[i] ? 1'b1      :
                                       arb_grant[j] ? 1'b0      : prio_q[P];
                end else if (i > j) begin : g_lower
                    localparam int unsigned P = pair_idx(j, i);
                    assign beats[i*NUM_INPUTS+j] = prio_q[P];
                end else begin : g_diag
                    assign beats[i*NUM_INPUTS+j] = 1'b1;
                end
            end
            assign win[i] = valid_in[i] && (&(beats[i*NUM_INPUTS +: NUM_INPUTS] | ~valid_in));
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                prio_q <= '0;
            end else begin
                prio_q <= prio_d;
            end
        end

`ifdef VX_STREAM_ARB_OUTBUF_EN
        always_comb begin
            arb_grant = win;
        end
`else
        logic            lock_valid_q;
        logic            lock_valid_d;
        logic [SELW-1:0] lock_idx_q;
        logic [SELW-1:0] lock_idx_d;
        logic            lock_hold;

        // A stalled output pins the grant so the presented payload cannot change.
        always_comb begin
            lock_valid_d = arb_valid && !ready_out;
            lock_idx_d   = arb_sel;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                lock_valid_q <= 1'b0;
                lock_idx_q   <= '0;
            end else begin
                lock_valid_q <= lock_valid_d;
                lock_idx_q   <= lock_idx_d;
            end
        end

        // A source dropping valid while locked falls back to normal arbitration.
        assign lock_hold = lock_valid_q && valid_in[lock_idx_q];

        always_comb begin
            arb_grant = lock_hold ? (NUM_INPUTS'(1) << lock_idx_q) : win;
        end

        always_ff @(posedge clk) begin
            if (!reset && lock_valid_q) begin
                assert (valid_in[lock_idx_q])
                    else $error("vx_stream_lru_arbiter: locked input %0d dropped valid", lock_idx_q);
            end
        end
`endif

        always_comb begin
            arb_sel  = '0;
            arb_data = '0;
            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                if (arb_grant[i]) begin
                    arb_sel  = SELW'(i);
                    arb_data = data_in[i*DATAW +: DATAW];
                end
            end
        end

        assign arb_valid = |valid_in;
    end

`ifdef VX_STREAM_ARB_OUTBUF_EN
    logic             out_valid_q;
    logic             out_valid_d;
    logic [DATAW-1:0] out_data_q;
    logic [DATAW-1:0] out_data_d;
    logic [SELW-1:0]  out_sel_q;
    logic [SELW-1:0]  out_sel_d;
    logic             skid_valid_q;
    logic             skid_valid_d;
    logic [DATAW-1:0] skid_data_q;
    logic [DATAW-1:0] skid_data_d;
    logic [SELW-1:0]  skid_sel_q;
    logic [SELW-1:0]  skid_sel_d;

    assign arb_ready = !skid_valid_q;

    // Output register refills from the skid entry first to keep arrival order.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_sel_d    = out_sel_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_sel_d   = skid_sel_q;
        if (!out_valid_q || ready_out) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_sel_d    = skid_sel_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = arb_fire;
                out_data_d  = arb_data;
                out_sel_d   = arb_sel;
            end
        end else if (arb_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = arb_data;
            skid_sel_d   = arb_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sel_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_sel_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sel_q    <= out_sel_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_sel_q   <= skid_sel_d;
        end
    end

    assign valid_out = out_valid_q;
    assign data_out  = out_data_q;
    assign sel_out   = out_sel_q;
`else
    assign arb_ready = ready_out;
    assign valid_out = arb_valid && !reset;
    assign data_out  = arb_data;
    assign sel_out   = arb_sel;
`endif

endmodule
